// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and tag-row helpers for the I-cache tag controller.
// Geometry: 16 sets x 4 ways x 8-bit tags; line address is {tag, index}.
package icache_pkg;

    localparam int TAG_WIDTH   = 8;
    localparam int INDEX_WIDTH = 4;
    localparam int NUM_WAYS    = 4;
    localparam int NUM_SETS    = 16;
    localparam int WAY_BITS    = 2;
    localparam int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH;
    localparam int ROW_WIDTH   = TAG_WIDTH * NUM_WAYS;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_MISS_REQ  = 3'd2,
        ST_MISS_WAIT = 3'd3,
        ST_FILL      = 3'd4,
        ST_FLUSH     = 3'd5
    } state_e;

    function automatic logic [TAG_WIDTH-1:0] way_tag(input logic [ROW_WIDTH-1:0] row,
                                                      input int way);
        return row[way*TAG_WIDTH +: TAG_WIDTH];
    endfunction

    // Per-way hit vector: a way hits only if its valid flop is set and its tag matches.
    function automatic logic [NUM_WAYS-1:0] tag_hits(input logic [ROW_WIDTH-1:0] row,
                                                      input logic [TAG_WIDTH-1:0] tag,
                                                      input logic [NUM_WAYS-1:0]  valid);
        logic [NUM_WAYS-1:0] hits;
        hits = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hits[w] = valid[w] & (way_tag(row, w) == tag);
        end
        return hits;
    endfunction

    function automatic logic [WAY_BITS-1:0] first_one(input logic [NUM_WAYS-1:0] v);
        logic [WAY_BITS-1:0] idx;
        idx = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (v[w]) idx = WAY_BITS'(w);
        end
        return idx;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection: lowest invalid way, else the round-robin pointer.
// advance_o tells the owner of the pointer to step it (only when the set is full).
module icache_victim_sel
    import icache_pkg::*;
(
    input  logic [NUM_WAYS-1:0] valid_i,
    input  logic [WAY_BITS-1:0] ptr_i,
    output logic [WAY_BITS-1:0] victim_o,
    output logic                advance_o
);

    always_comb begin
        advance_o = &valid_i;
        victim_o  = advance_o ? ptr_i : first_one(~valid_i);
    end

endmodule

// File: rtl/icache_tag_ctrl.sv
// Sequencing controller for the 4-way instruction-cache tag SRAM: lookup, miss refill,
// victim fill and a 16-row flush sweep. Valid bits live in flops here, not in the SRAM.
module icache_tag_ctrl
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_stall,
    input  logic                   i_req_valid,
    input  logic [ADDR_WIDTH-1:0]  i_req_addr,
    output logic                   o_req_ready,
    output logic                   o_resp_valid,
    output logic                   o_resp_hit,
    output logic [WAY_BITS-1:0]    o_resp_way,
    input  logic                   i_flush,
    output logic                   o_flush_busy,
    output logic                   o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
    input  logic                   i_mem_req_ready,
    input  logic                   i_mem_done,
    output logic [INDEX_WIDTH-1:0] o_ta_r_addr,
    output logic                   o_ta_r_valid,
    output logic [TAG_WIDTH-1:0]   o_ta_tag,
    input  logic [ROW_WIDTH-1:0]   i_ta_data,
    input  logic                   i_ta_valid,
    output logic [INDEX_WIDTH-1:0] o_ta_w_addr,
    output logic [ROW_WIDTH-1:0]   o_ta_w_data,
    output logic [NUM_WAYS-1:0]    o_ta_w_wmask,
    output logic                   o_ta_w_valid,
    output logic                   o_ta_halt,
    output logic                   o_ta_w_clk_en,
    output logic [2:0]             o_dbg_state
);

    // Handshakes: a request transfers on a rising edge where i_req_valid & o_req_ready;
    // the refill request transfers where o_mem_req_valid & i_mem_req_ready & ~i_stall.

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
    logic [WAY_BITS-1:0]    rr_q, rr_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [INDEX_WIDTH-1:0] row_q, row_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_hit_q, resp_hit_d;
    logic [WAY_BITS-1:0]    resp_way_q, resp_way_d;

    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [NUM_WAYS-1:0]    set_valid;
    logic [NUM_WAYS-1:0]    hits;
    logic [WAY_BITS-1:0]    victim;
    logic                   rr_advance;
    logic                   fill_we;
    logic                   flush_we;

    assign tag_q     = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign idx_q     = addr_q[INDEX_WIDTH-1:0];
    assign set_valid = valid_q[idx_q];
    assign hits      = tag_hits(i_ta_data, tag_q, set_valid);

    icache_victim_sel u_victim_sel (
        .valid_i   (set_valid),
        .ptr_i     (rr_q),
        .victim_o  (victim),
        .advance_o (rr_advance)
    );

    assign o_resp_valid   = resp_valid_q;
    assign o_resp_hit     = resp_hit_q;
    assign o_resp_way     = resp_way_q;
    assign o_mem_req_addr = addr_q;
    assign o_flush_busy   = flush_pend_q | (state_q == ST_FLUSH);
    assign o_ta_halt      = i_stall;
    assign o_ta_w_clk_en  = ~i_stall;
    assign o_dbg_state    = state_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rr_d         = rr_q;
        flush_pend_d = flush_pend_q | i_flush;
        row_d        = row_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        o_req_ready     = 1'b0;
        o_ta_r_valid    = 1'b0;
        o_ta_r_addr     = idx_q;
        o_ta_tag        = tag_q;
        o_mem_req_valid = 1'b0;
        o_ta_w_valid    = 1'b0;
        o_ta_w_addr     = idx_q;
        o_ta_w_data     = {NUM_WAYS{tag_q}};
        o_ta_w_wmask    = '0;
        fill_we         = 1'b0;
        flush_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_ta_r_addr = i_req_addr[INDEX_WIDTH-1:0];
                o_ta_tag    = i_req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
                // A flush (pending or arriving now) wins, so ready is withheld for it too.
                if (flush_pend_q | i_flush) begin
                    state_d = ST_FLUSH;
                    row_d   = '0;
                end else begin
                    o_req_ready = ~i_stall;
                    if (i_req_valid & ~i_stall) begin
                        o_ta_r_valid = ~rst;
                        addr_d       = i_req_addr;
                        state_d      = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                if (i_ta_valid) begin
                    if (|hits) begin
                        resp_valid_d = 1'b1;
                        resp_hit_d   = 1'b1;
                        resp_way_d   = first_one(hits);
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_MISS_REQ;
                    end
                end
            end
            ST_MISS_REQ: begin
                o_mem_req_valid = ~rst;
                if (i_mem_req_ready) state_d = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (i_mem_done) state_d = ST_FILL;
            end
            ST_FILL: begin
                o_ta_w_valid = ~i_stall & ~rst;
                o_ta_w_wmask = NUM_WAYS'(1) << victim;
                fill_we      = 1'b1;
                resp_valid_d = 1'b1;
                resp_hit_d   = 1'b0;
                resp_way_d   = victim;
                if (rr_advance) rr_d = rr_q + WAY_BITS'(1);
                state_d      = ST_IDLE;
            end
            ST_FLUSH: begin
                o_ta_w_valid = ~i_stall & ~rst;
                o_ta_w_addr  = row_q;
                o_ta_w_data  = '0;
                o_ta_w_wmask = '1;
                flush_we     = 1'b1;
                row_d        = row_q + INDEX_WIDTH'(1);
                if (row_q == INDEX_WIDTH'(NUM_SETS - 1)) begin
                    flush_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rr_q         <= '0;
            flush_pend_q <= 1'b0;
            row_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else if (!i_stall) begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rr_q         <= rr_d;
            flush_pend_q <= flush_pend_d;
            row_q        <= row_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            if (fill_we)  valid_q[idx_q][victim] <= 1'b1;
            if (flush_we) valid_q[row_q] <= '0;
        end
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Bench for icache_tag_ctrl: behavioural tag SRAM and memory responder around the DUT,
// expected responses queued at request time and checked when the response pulse appears.
`timescale 1ns/1ps
module tb_icache_tag_ctrl;
  import icache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, i_stall = 1'b0, i_req_valid = 1'b0, i_flush = 1'b0;
  logic [11:0] i_req_addr = '0;
  logic i_mem_req_ready = 1'b0, i_mem_done = 1'b0;
  logic [31:0] i_ta_data;
  logic i_ta_valid;
  logic o_req_ready, o_resp_valid, o_resp_hit, o_flush_busy, o_mem_req_valid;
  logic [1:0] o_resp_way;
  logic [11:0] o_mem_req_addr;
  logic [3:0] o_ta_r_addr, o_ta_w_addr, o_ta_w_wmask;
  logic o_ta_r_valid, o_ta_w_valid, o_ta_halt, o_ta_w_clk_en;
  logic [7:0] o_ta_tag;
  logic [31:0] o_ta_w_data;
  logic [2:0] o_dbg_state;

  int errors = 0, checks = 0, cyc = 0;
  int ready_dly = 1, done_dly = 2;
  int clash = 0, flush_ready = 0;
  logic [2:0] exp_q[$];
  logic [2:0] resp_log[$];
  int resp_cyc[$];
  logic [11:0] memreq_log[$];
  logic [39:0] wr_log[$];
  int wr_cyc[$];

  icache_tag_ctrl dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid), .o_resp_hit(o_resp_hit),
    .o_resp_way(o_resp_way), .i_flush(i_flush), .o_flush_busy(o_flush_busy),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_done(i_mem_done), .o_ta_r_addr(o_ta_r_addr),
    .o_ta_r_valid(o_ta_r_valid), .o_ta_tag(o_ta_tag), .i_ta_data(i_ta_data),
    .i_ta_valid(i_ta_valid), .o_ta_w_addr(o_ta_w_addr), .o_ta_w_data(o_ta_w_data),
    .o_ta_w_wmask(o_ta_w_wmask), .o_ta_w_valid(o_ta_w_valid), .o_ta_halt(o_ta_halt),
    .o_ta_w_clk_en(o_ta_w_clk_en), .o_dbg_state(o_dbg_state)
  );

  // Clock/reset-side bookkeeping and tag SRAM model (masked write, 1-cycle read).
  logic [31:0] tmem [16];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_ta_w_valid && o_ta_w_clk_en) begin
      for (int w = 0; w < 4; w++)
        if (o_ta_w_wmask[w]) tmem[o_ta_w_addr][8*w +: 8] <= o_ta_w_data[8*w +: 8];
    end
    if (rst) i_ta_valid <= 1'b0;
    else if (!o_ta_halt) begin
      i_ta_valid <= o_ta_r_valid;
      if (o_ta_r_valid) i_ta_data <= o_ta_w_valid ? 32'h0 : tmem[o_ta_r_addr];
    end
  end

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_resp_valid) begin
      resp_log.push_back({o_resp_hit, o_resp_way});
      resp_cyc.push_back(cyc);
    end
    if (o_mem_req_valid && i_mem_req_ready && !i_stall && !rst) memreq_log.push_back(o_mem_req_addr);
    if (o_ta_w_valid) begin
      wr_log.push_back({o_ta_w_addr, o_ta_w_data, o_ta_w_wmask});
      wr_cyc.push_back(cyc);
    end
    if (o_ta_w_valid && o_ta_r_valid) clash++;
    if (o_flush_busy && o_req_ready) flush_ready++;
  end

  // Memory responder: accept after ready_dly cycles, signal done after done_dly more.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (o_mem_req_valid && !rst) begin
        repeat (ready_dly) begin @(posedge clk); #1; end
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_req_ready = 1'b0;
        repeat (done_dly) begin @(posedge clk); #1; end
        i_mem_done = 1'b1;
        @(posedge clk); #1;
        i_mem_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Drivers
  task automatic issue_req(input logic [7:0] tag, input logic [3:0] idx, input bit push,
                           input logic [2:0] exp, output int acc_cyc, output bit ok);
    int n = 0;
    @(posedge clk); #1;
    i_req_valid = 1'b1;
    i_req_addr  = {tag, idx};
    @(negedge clk);
    while (!o_req_ready && n < 300) begin @(negedge clk); n++; end
    ok = o_req_ready && (o_ta_r_valid === 1'b1) && (o_ta_r_addr === idx) && (o_ta_tag === tag);
    if (push) exp_q.push_back(exp);
    acc_cyc = cyc;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic get_resp(output logic [2:0] got, output logic [2:0] exp, output int rcyc,
                          output bit ok);
    int n = 0;
    while (resp_log.size() == 0 && n < 400) begin @(negedge clk); n++; end
    ok = (resp_log.size() != 0) && (exp_q.size() != 0);
    got = 3'bxxx; exp = 3'bxxx; rcyc = -1;
    if (resp_log.size() != 0) begin got = resp_log.pop_front(); rcyc = resp_cyc.pop_front(); end
    if (exp_q.size() != 0) exp = exp_q.pop_front();
  endtask

  task automatic wait_state(input logic [2:0] st, output bit ok);
    int n = 0;
    @(negedge clk);
    while (o_dbg_state !== st && n < 300) begin @(negedge clk); n++; end
    ok = (o_dbg_state === st);
  endtask

  task automatic clear_logs();
    memreq_log.delete(); wr_log.delete(); wr_cyc.delete();
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1; i_req_valid = 1'b1; i_req_addr = 12'h3A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_ta_r_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", o_ta_r_valid); end
    checks++;
    if ({o_resp_valid, o_mem_req_valid, o_ta_w_valid, o_flush_busy, o_resp_hit, o_resp_way} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {o_resp_valid, o_mem_req_valid, o_ta_w_valid, o_flush_busy, o_resp_hit, o_resp_way});
    end
    checks++;
    if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_dbg_state); end
    @(posedge clk); #1;
    rst = 1'b0; i_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_req_ready); end
    clear_logs();
  endtask

  task automatic test_cold_miss();
    int acc, rc; bit ok; logic [2:0] got, exp;
    issue_req(8'h3A, 4'h5, 1, 3'b0_00, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cold_accept got=0 exp=1"); end
    get_resp(got, exp, rc, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL cold_resp got=%b exp=%b", got, exp); end
    checks++;
    if (memreq_log.size() != 1 || memreq_log[0] !== 12'h3A5) begin
      errors++; $display("FAIL cold_memreq count=%0d exp_addr=3a5", memreq_log.size());
    end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== {4'h5, 32'h3A3A3A3A, 4'b0001}) begin
      errors++; $display("FAIL cold_fill_write count=%0d exp=5_3a3a3a3a_1", wr_log.size());
    end
    clear_logs();
  endtask

  task automatic test_hit();
    int acc, rc; bit ok; logic [2:0] got, exp;
    issue_req(8'h3A, 4'h5, 1, 3'b1_00, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hit_accept got=0 exp=1"); end
    get_resp(got, exp, rc, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL hit_resp got=%b exp=%b", got, exp); end
    checks++;
    if (rc - acc != 2) begin errors++; $display("FAIL hit_latency got=%0d exp=2", rc - acc); end
    checks++;
    if (memreq_log.size() != 0 || wr_log.size() != 0) begin
      errors++; $display("FAIL hit_no_mem got=%0d/%0d exp=0/0", memreq_log.size(), wr_log.size());
    end
    clear_logs();
  endtask

  task automatic test_set_full();
    logic [7:0] tags [8];
    logic [2:0] exps [8];
    int acc, rc; bit ok; logic [2:0] got, exp;
    tags = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h12, 8'h10};
    exps = '{3'b0_00, 3'b0_01, 3'b0_10, 3'b0_11, 3'b0_00, 3'b0_01, 3'b1_10, 3'b0_10};
    for (int i = 0; i < 8; i++) begin
      clear_logs();
      issue_req(tags[i], 4'h2, 1, exps[i], acc, ok);
      get_resp(got, exp, rc, ok);
      checks++;
      if (!ok || got !== exp) begin errors++; $display("FAIL set_full_resp[%0d] got=%b exp=%b", i, got, exp); end
      if (!exps[i][2]) begin
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {4'h2, {4{tags[i]}}, 4'(4'b0001 << exps[i][1:0])}) begin
          errors++; $display("FAIL set_full_write[%0d] count=%0d exp_way=%0d", i, wr_log.size(), exps[i][1:0]);
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_flush();
    int acc, rc; bit ok; logic [2:0] got, exp;
    done_dly = 6;
    issue_req(8'h20, 4'h7, 1, 3'b0_00, acc, ok);
    wait_state(ST_MISS_WAIT, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_reach_wait got=%0d exp=3", o_dbg_state); end
    @(posedge clk); #1; i_flush = 1'b1;
    @(posedge clk); #1; i_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (o_flush_busy !== 1'b1) begin errors++; $display("FAIL flush_busy_pending got=%b exp=1", o_flush_busy); end
    get_resp(got, exp, rc, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL flush_miss_resp got=%b exp=%b", got, exp); end
    issue_req(8'h3A, 4'h5, 1, 3'b0_00, acc, ok);
    get_resp(got, exp, rc, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL flush_after_resp got=%b exp=%b", got, exp); end
    checks++;
    if (wr_log.size() != 18) begin
      errors++; $display("FAIL flush_write_count got=%0d exp=18", wr_log.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (wr_log[k+1] !== {4'(k), 32'h0, 4'hF} || wr_cyc[k+1] != wr_cyc[1] + k) begin
          errors++; $display("FAIL flush_row[%0d] got=%h exp=%h", k, wr_log[k+1], {4'(k), 32'h0, 4'hF});
        end
      end
      checks++;
      if (wr_log[17] !== {4'h5, 32'h3A3A3A3A, 4'b0001}) begin
        errors++; $display("FAIL flush_refill got=%h exp=53a3a3a3a1", wr_log[17]);
      end
    end
    checks++;
    if (flush_ready != 0 || o_flush_busy !== 1'b0) begin
      errors++; $display("FAIL flush_ready_low got=%0d/%b exp=0/0", flush_ready, o_flush_busy);
    end
    done_dly = 2;
    clear_logs();
  endtask

  task automatic test_stall();
    int acc, rc, bad; bit ok; logic [2:0] got, exp;
    ready_dly = 10;
    bad = 0;
    issue_req(8'h41, 4'h9, 1, 3'b0_00, acc, ok);
    wait_state(ST_MISS_REQ, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_reach_req got=%0d exp=2", o_dbg_state); end
    @(posedge clk); #1; i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(o_mem_req_valid === 1'b1 && o_ta_halt === 1'b1 && o_ta_w_clk_en === 1'b0 &&
            o_dbg_state === ST_MISS_REQ && o_req_ready === 1'b0 && o_ta_w_valid === 1'b0)) bad++;
    end
    @(posedge clk); #1; i_stall = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    get_resp(got, exp, rc, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL stall_resp got=%b exp=%b", got, exp); end
    checks++;
    if (memreq_log.size() != 1 || memreq_log[0] !== 12'h419) begin
      errors++; $display("FAIL stall_memreq count=%0d exp_addr=419", memreq_log.size());
    end
    ready_dly = 1;
    issue_req(8'h41, 4'h9, 1, 3'b1_00, acc, ok);
    get_resp(got, exp, rc, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL stall_rehit got=%b exp=%b", got, exp); end
    clear_logs();
  endtask

  task automatic test_reset_fill();
    logic [7:0] tags [3];
    logic [3:0] idxs [3];
    int acc, rc; bit ok; logic [2:0] got, exp;
    tags = '{8'h3A, 8'h12, 8'h55};
    idxs = '{4'h5, 4'h2, 4'h3};
    issue_req(8'h55, 4'h3, 0, 3'b0, acc, ok);
    wait_state(ST_FILL, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstfill_reach got=%0d exp=4", o_dbg_state); end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (resp_log.size() != 0 || o_dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rstfill_no_resp got=%0d/%0d exp=0/0", resp_log.size(), o_dbg_state);
    end
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      issue_req(tags[i], idxs[i], 1, 3'b0_00, acc, ok);
      get_resp(got, exp, rc, ok);
      checks++;
      if (!ok || got !== exp) begin errors++; $display("FAIL rstfill_miss[%0d] got=%b exp=%b", i, got, exp); end
    end
    checks++;
    if (memreq_log.size() != 3) begin errors++; $display("FAIL rstfill_memreqs got=%0d exp=3", memreq_log.size()); end
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_set_full();
    test_flush();
    test_stall();
    test_reset_fill();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || resp_log.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_q.size(), resp_log.size());
    end
    checks++;
    if (clash != 0) begin errors++; $display("FAIL rw_exclusive got=%0d exp=0", clash); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
